// File: rtl/dcache_ctrl_pkg.sv
// Shared widths, FSM state encodings and the byte-merge helper for the
// direct-mapped, write-through, no-write-allocate data cache.
package dcache_ctrl_pkg;

    localparam int ADDR_W           = 32;
    localparam int DATA_W           = 32;
    localparam int DCACHE_NUM_LINES = 64;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_MISS_REQ  = 2'd1;
    localparam logic [1:0] ST_MISS_WAIT = 2'd2;
    localparam logic [1:0] ST_FILLED    = 2'd3;

    localparam logic [ADDR_W-1:0] WORD_ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

    // One CPU access as sampled on the capture edge.
    typedef struct packed {
        logic              re;
        logic [3:0]        we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] din;
    } cpu_req_t;

    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] new_word,
        input logic [3:0]        mask
    );
        logic [DATA_W-1:0] merged;
        merged = old_word;
        for (int b = 0; b < 4; b++) begin
            if (mask[b]) merged[8*b +: 8] = new_word[8*b +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Line storage for the data cache: valid bit, tag and one data word per line.
// Combinational read and byte-masked synchronous write share one line index.
module dcache_array
    import dcache_ctrl_pkg::*;
#(
    parameter int NUM_LINES = DCACHE_NUM_LINES,
    parameter int IDX_W     = $clog2(NUM_LINES),
    parameter int TAG_W     = ADDR_W - IDX_W - 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [IDX_W-1:0]  idx_i,
    output logic              rd_valid_o,
    output logic [TAG_W-1:0]  rd_tag_o,
    output logic [DATA_W-1:0] rd_data_o,
    input  logic              wr_en_i,
    input  logic [TAG_W-1:0]  wr_tag_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [3:0]        wr_mask_i
);

    logic [NUM_LINES-1:0] valid_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [DATA_W-1:0]    data_q [NUM_LINES];

    assign rd_valid_o = valid_q[idx_i];
    assign rd_tag_o   = tag_q[idx_i];
    assign rd_data_o  = data_q[idx_i];

    // NOTE: state updates use <= so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
        end else if (wr_en_i) begin
            valid_q[idx_i] <= 1'b1;
        end
    end

    // NOTE: tag/data storage is deliberately not reset; the valid bits alone gate its use.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            tag_q[idx_i]  <= wr_tag_i;
            data_q[idx_i] <= merge_bytes(data_q[idx_i], wr_data_i, wr_mask_i);
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Data-cache controller: captures CPU accesses, serves load hits in one cycle,
// refills on load misses and writes every store through to backing memory.
module dcache_ctrl
    import dcache_ctrl_pkg::*;
#(
    parameter int NUM_LINES = DCACHE_NUM_LINES
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              cpu_re_i,
    input  logic [3:0]        cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_din_i,
    output logic [DATA_W-1:0] cpu_dout_o,
    output logic              mem_stall_o,
    output logic              mem_req_valid_o,
    input  logic              mem_req_ready_i,
    output logic              mem_req_rw_o,
    output logic [ADDR_W-1:0] mem_req_addr_o,
    output logic [DATA_W-1:0] mem_req_data_o,
    output logic [3:0]        mem_req_mask_o,
    input  logic              mem_resp_valid_i,
    input  logic [DATA_W-1:0] mem_resp_data_i
);

    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    logic [1:0]        state_q, state_d;
    cpu_req_t          pend_q, pend_d;
    logic [DATA_W-1:0] dout_q, dout_d;

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic              line_valid;
    logic [TAG_W-1:0]  line_tag;
    logic [DATA_W-1:0] line_data;
    logic              hit;
    logic              is_store;
    logic              is_load;
    logic              load_hit;

    logic              arr_wr_en;
    logic [DATA_W-1:0] arr_wr_data;
    logic [3:0]        arr_wr_mask;
    logic              req_valid;
    logic              req_rw;
    logic              stall;
    logic              capture;

    assign idx      = pend_q.addr[IDX_W+1:2];
    assign tag      = pend_q.addr[ADDR_W-1:IDX_W+2];
    assign hit      = line_valid && (line_tag == tag);
    assign is_store = |pend_q.we;
    assign is_load  = pend_q.re && !is_store;
    assign load_hit = (state_q == ST_IDLE) && is_load && hit;

    dcache_array #(
        .NUM_LINES (NUM_LINES),
        .IDX_W     (IDX_W),
        .TAG_W     (TAG_W)
    ) u_array (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .idx_i      (idx),
        .rd_valid_o (line_valid),
        .rd_tag_o   (line_tag),
        .rd_data_o  (line_data),
        .wr_en_i    (arr_wr_en),
        .wr_tag_i   (tag),
        .wr_data_i  (arr_wr_data),
        .wr_mask_i  (arr_wr_mask)
    );

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        dout_d      = dout_q;
        req_valid   = 1'b0;
        req_rw      = 1'b0;
        stall       = 1'b0;
        arr_wr_en   = 1'b0;
        arr_wr_data = pend_q.din;
        arr_wr_mask = pend_q.we;

        case (state_q)
            ST_IDLE: begin
                if (is_store) begin
                    // Write-through: only a hit touches the array, and only on the handshake edge.
                    req_valid = 1'b1;
                    req_rw    = 1'b1;
                    stall     = !mem_req_ready_i;
                    arr_wr_en = mem_req_ready_i && hit;
                end else if (is_load) begin
                    if (hit) begin
                        dout_d = line_data;
                    end else begin
                        // A request accepted here must not be re-issued from MISS_REQ.
                        req_valid = 1'b1;
                        stall     = 1'b1;
                        state_d   = mem_req_ready_i ? ST_MISS_WAIT : ST_MISS_REQ;
                    end
                end
            end
            ST_MISS_REQ: begin
                req_valid = 1'b1;
                stall     = 1'b1;
                if (mem_req_ready_i) state_d = ST_MISS_WAIT;
            end
            ST_MISS_WAIT: begin
                stall = 1'b1;
                if (mem_resp_valid_i) begin
                    arr_wr_en   = 1'b1;
                    arr_wr_data = mem_resp_data_i;
                    arr_wr_mask = 4'b1111;
                    dout_d      = mem_resp_data_i;
                    state_d     = ST_FILLED;
                end
            end
            ST_FILLED: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        capture = ((state_q == ST_IDLE) || (state_q == ST_FILLED)) && !stall;
        if (capture) begin
            pend_d = '{re: cpu_re_i, we: cpu_we_i, addr: cpu_addr_i, din: cpu_din_i};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            pend_q  <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            dout_q  <= dout_d;
        end
    end

    // A hit is returned in the cycle after capture, ahead of the registered copy.
    assign cpu_dout_o      = load_hit ? line_data : dout_q;
    assign mem_stall_o     = stall;
    assign mem_req_valid_o = req_valid;
    assign mem_req_rw_o    = req_rw;
    assign mem_req_addr_o  = req_valid ? (pend_q.addr & WORD_ALIGN_MASK) : '0;
    assign mem_req_data_o  = req_rw ? pend_q.din : '0;
    assign mem_req_mask_o  = req_rw ? pend_q.we : 4'b0000;

endmodule
